// File: rtl/conv_axis_pkg.sv
// Shared types and default widths for the conv output AXI4-Stream path.
// Holds the beat layout, the framer state encoding and default widths.
package conv_axis_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 64;
    localparam int unsigned FIFO_DEPTH_DEF = 16;
    localparam int unsigned CNT_WIDTH_DEF  = 32;
    localparam int unsigned KEEP_WIDTH_DEF = DATA_WIDTH_DEF / 8;

    // Beat payload at default width; modules with other widths rebuild it locally
    typedef struct packed {
        logic [DATA_WIDTH_DEF-1:0] data;
        logic [KEEP_WIDTH_DEF-1:0] keep;
        logic                      last;
    } conv_beat_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } framer_state_e;

    function automatic int unsigned beat_width(input int unsigned dw);
        return dw + (dw / 8) + 1;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with registered storage, full/empty flags and fill level.
// Head entry is presented on dout_o whenever the FIFO is not empty.
module axis_sync_fifo #(
    parameter int unsigned WIDTH = 73,
    parameter int unsigned DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             din_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             dout_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        if (do_push) wr_d = wr_q + AW'(1);
        if (do_pop)  rd_d = rd_q + AW'(1);
    end

    // Storage is cleared on reset so the head output reads zero when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[AW'(i)] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) mem_q[wr_q] <= din_i;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/conv_output_framer.sv
// Frames the conv kernel output stream: buffers beats, counts them against a
// per-invocation beat count, regenerates tlast and flags upstream framing errors.
module conv_output_framer
    import conv_axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    start,
    input  logic [CNT_WIDTH-1:0]    cfg_out_beats,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    err_early_tlast,
    output logic                    err_late_tlast
);

    localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned BEAT_WIDTH = beat_width(DATA_WIDTH);
    localparam int unsigned LVL_WIDTH  = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_WIDTH-1:0] keep;
        logic                  last;
    } beat_t;

    framer_state_e        state_q, state_d;
    logic [CNT_WIDTH-1:0] n_q, n_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 early_q, early_d;
    logic                 late_q, late_d;
    logic                 done_q, done_d;

    beat_t                push_beat, head_beat;
    logic                 fifo_full, fifo_empty;
    logic [LVL_WIDTH-1:0] fifo_level;
    logic                 accept, pop, is_last, tag_pop;

    assign s_axis_tready = (state_q == ST_RUN) && !fifo_full;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign m_axis_tvalid = !fifo_empty;
    assign pop           = m_axis_tvalid && m_axis_tready;
    // Compare against N-1 so the full counter range is usable without wrap
    assign is_last       = (cnt_q == n_q - CNT_WIDTH'(1));
    // In DRAIN nothing is pushed, so the tagged beat is the sole remaining entry
    assign tag_pop       = pop && head_beat.last && (fifo_level == LVL_WIDTH'(1));

    assign push_beat = '{data: s_axis_tdata, keep: s_axis_tkeep, last: is_last};

    axis_sync_fifo #(
        .WIDTH (BEAT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .push_i  (accept),
        .din_i   (push_beat),
        .pop_i   (pop),
        .dout_o  (head_beat),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_level)
    );

    assign m_axis_tdata    = head_beat.data;
    assign m_axis_tkeep    = head_beat.keep;
    assign m_axis_tlast    = head_beat.last;
    assign busy            = (state_q != ST_IDLE);
    assign frame_done      = done_q;
    assign err_early_tlast = early_q;
    assign err_late_tlast  = late_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            early_q <= 1'b0;
            late_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            early_q <= early_d;
            late_q  <= late_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start && (cfg_out_beats != '0)) state_d = ST_RUN;
            ST_RUN:   if (accept && is_last)              state_d = ST_DRAIN;
            ST_DRAIN: if (tag_pop)                        state_d = ST_IDLE;
            default:                                      state_d = ST_IDLE;
        endcase
    end

    // Frame bookkeeping: beat count, sticky framing errors and the done pulse
    always_comb begin
        n_d     = n_q;
        cnt_d   = cnt_q;
        early_d = early_q;
        late_d  = late_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_out_beats == '0) begin
                        done_d = 1'b1;
                    end else begin
                        n_d     = cfg_out_beats;
                        cnt_d   = '0;
                        early_d = 1'b0;
                        late_d  = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (s_axis_tlast && !is_last) early_d = 1'b1;
                    if (!s_axis_tlast && is_last) late_d  = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (tag_pop) done_d = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_conv_output_framer.sv
// Directed and randomized frames checked against a beat-list model of the
// framer: first N offered beats leave in order, tlast only on beat N-1.
module tb_conv_output_framer;

    localparam int unsigned DW    = 64;
    localparam int unsigned KW    = DW / 8;
    localparam int unsigned CW    = 32;
    localparam int unsigned DEPTH = 16;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic          start;
    logic [CW-1:0] cfg_out_beats;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          s_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic          busy;
    logic          frame_done;
    logic          err_early_tlast;
    logic          err_late_tlast;

    int checks = 0;
    int errors = 0;

    conv_output_framer #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .ap_clk          (ap_clk),
        .ap_rst_n        (ap_rst_n),
        .start           (start),
        .cfg_out_beats   (cfg_out_beats),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tkeep    (s_axis_tkeep),
        .s_axis_tlast    (s_axis_tlast),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tkeep    (m_axis_tkeep),
        .m_axis_tlast    (m_axis_tlast),
        .busy            (busy),
        .frame_done      (frame_done),
        .err_early_tlast (err_early_tlast),
        .err_late_tlast  (err_late_tlast)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m_tvalid"}, 64'(m_axis_tvalid), 64'd0);
        chk({tag, "_m_tdata"},  m_axis_tdata,       64'd0);
        chk({tag, "_m_tkeep"},  64'(m_axis_tkeep),  64'd0);
        chk({tag, "_m_tlast"},  64'(m_axis_tlast),  64'd0);
        chk({tag, "_s_tready"}, 64'(s_axis_tready), 64'd0);
        chk({tag, "_busy"},     64'(busy),          64'd0);
        chk({tag, "_done"},     64'(frame_done),    64'd0);
        chk({tag, "_errs"},     64'({err_early_tlast, err_late_tlast}), 64'd0);
    endtask

    // One frame of n beats with 'offered' upstream beats; tlast_at<0 means no upstream tlast.
    task automatic do_frame(input string nm, input int n, input int offered, input int tlast_at,
                            input int stall, input bit rnd_ready, input int restart_at);
        logic [DW-1:0] dat[$];
        logic [KW-1:0] kp[$];
        int            acc_cyc[$];
        int            sent = 0, outc = 0, done_cnt = 0, last_out = -1, done_cyc = -1;
        bit            exp_early, exp_late, pv = 0, pr = 0, timing;
        logic [DW-1:0] pd, base;
        logic [KW-1:0] pk;
        logic          pl;
        int            maxc = 4 * offered + stall + 60;

        base   = {$urandom, $urandom};
        timing = (stall == 0) && !rnd_ready;
        for (int i = 0; i < offered; i++) begin
            dat.push_back(base + DW'(i));
            kp.push_back(KW'($urandom));
        end
        exp_early = (tlast_at >= 0) && (tlast_at < n - 1);
        exp_late  = (n > 0) && (tlast_at != n - 1);

        @(negedge ap_clk);
        start = 1'b1;
        cfg_out_beats = CW'(n);
        @(negedge ap_clk);
        start = 1'b0;
        cfg_out_beats = CW'($urandom);

        for (int c = 0; c < maxc; c++) begin
            if (c > 0) @(negedge ap_clk);
            if (c == 0 && n != 0) begin
                chk({nm, "_busy_start"}, 64'(busy), 64'd1);
                chk({nm, "_flags_cleared"}, 64'({err_early_tlast, err_late_tlast}), 64'd0);
            end
            if (n == 0) begin
                chk({nm, "_busy_idle"},   64'(busy),          64'd0);
                chk({nm, "_tready_idle"}, 64'(s_axis_tready), 64'd0);
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (pv && !pr) begin
                chk({nm, "_hold_valid"}, 64'(m_axis_tvalid), 64'd1);
                chk({nm, "_hold_data"},  m_axis_tdata,       pd);
                chk({nm, "_hold_keep"},  64'(m_axis_tkeep),  64'(pk));
                chk({nm, "_hold_last"},  64'(m_axis_tlast),  64'(pl));
            end
            if (stall >= 2 * DEPTH && c == stall - 1) begin
                chk({nm, "_fill_accepts"}, 64'(sent),          64'(DEPTH));
                chk({nm, "_full_tready"},  64'(s_axis_tready), 64'd0);
            end

            start = (c == restart_at);
            if (c == restart_at) cfg_out_beats = CW'(3);
            s_axis_tvalid = (sent < offered);
            s_axis_tdata  = (sent < offered) ? dat[sent] : DW'($urandom);
            s_axis_tkeep  = (sent < offered) ? kp[sent]  : KW'($urandom);
            s_axis_tlast  = (sent == tlast_at);
            if (c < stall)      m_axis_tready = 1'b0;
            else if (rnd_ready) m_axis_tready = ($urandom_range(0, 3) != 0);
            else                m_axis_tready = 1'b1;

            if (s_axis_tvalid && s_axis_tready) begin
                chk({nm, "_no_over_accept"}, 64'(sent < n), 64'd1);
                acc_cyc.push_back(c);
                sent++;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (outc < offered) begin
                    chk({nm, "_out_data"}, m_axis_tdata,      dat[outc]);
                    chk({nm, "_out_keep"}, 64'(m_axis_tkeep), 64'(kp[outc]));
                end
                chk({nm, "_out_last"}, 64'(m_axis_tlast), 64'(outc == n - 1));
                if (timing && outc < acc_cyc.size())
                    chk({nm, "_latency"}, 64'(c), 64'(acc_cyc[outc] + 1));
                last_out = c;
                outc++;
            end
            pv = m_axis_tvalid; pr = m_axis_tready;
            pd = m_axis_tdata;  pk = m_axis_tkeep; pl = m_axis_tlast;
            if (done_cnt > 0 && c >= done_cyc + 3) break;
        end

        chk({nm, "_beats_out"},   64'(outc),     64'(n));
        chk({nm, "_beats_in"},    64'(sent),     64'(n));
        chk({nm, "_done_count"},  64'(done_cnt), 64'd1);
        chk({nm, "_done_cycle"},  64'(done_cyc), 64'(last_out + 1));
        chk({nm, "_busy_end"},    64'(busy),     64'd0);
        chk({nm, "_tready_end"},  64'(s_axis_tready), 64'd0);
        chk({nm, "_early"},       64'(err_early_tlast), 64'(exp_early));
        chk({nm, "_late"},        64'(err_late_tlast),  64'(exp_late));
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        start         = 1'b0;
    endtask

    initial begin
        int n, sel, tl;
        ap_rst_n      = 1'b0;
        start         = 1'b0;
        cfg_out_beats = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        #12;
        chk_all_zero("reset");
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk_all_zero("post_reset");

        do_frame("n8",       8,  8,  7,  0, 1'b0, -1);
        do_frame("stall",    64, 64, 63, 40, 1'b0, -1);
        do_frame("early",    4,  10, 1,  0, 1'b0, -1);
        do_frame("late",     4,  4,  -1, 0, 1'b0, -1);
        do_frame("clear",    8,  8,  7,  0, 1'b1, -1);
        do_frame("zero",     0,  0,  -1, 0, 1'b0, -1);
        do_frame("restart",  8,  8,  7,  0, 1'b0, 2);

        // Reset in the middle of a frame with beats still buffered
        @(negedge ap_clk);
        start = 1'b1;
        cfg_out_beats = CW'(8);
        @(negedge ap_clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = DW'(64'hA5A5_0000 + 64'(i));
            s_axis_tkeep  = '1;
            s_axis_tlast  = 1'b0;
            @(negedge ap_clk);
        end
        s_axis_tvalid = 1'b0;
        chk("midrst_buffered", 64'(m_axis_tvalid), 64'd1);
        chk("midrst_busy",     64'(busy),          64'd1);
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ap_clk);
            chk("midrst_no_done", 64'(frame_done),    64'd0);
            chk("midrst_empty",   64'(m_axis_tvalid), 64'd0);
        end
        do_frame("after_rst", 2, 2, 1, 0, 1'b0, -1);

        for (int k = 0; k < 6; k++) begin
            n   = $urandom_range(1, 40);
            sel = $urandom_range(0, 2);
            tl  = (sel == 0) ? n - 1 : (sel == 1) ? $urandom_range(0, n - 1) : -1;
            do_frame("rand", n, n + $urandom_range(0, 3), tl, $urandom_range(0, 5), 1'b1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
